// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one full-adder cell plus a carry flop.
// Adds two WIDTH-bit operands and a carry-in LSB first, one bit per clock.
// A start/busy/done handshake frames each operation. The visible sum, cout
// and ovf are loaded only on entry to DONE, so they never show partial values.
// They hold until the next operation completes or reset is applied.
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN enables signed overflow
// detection on ovf; when undefined, ovf is tied to 0.

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Operand shift registers, carry flop, bit counter and internal sum.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_sh;

    // Visible, held results.
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic accept;
    logic last_bit;
    logic s_bit;
    logic c_bit;
    logic [WIDTH-1:0] sum_final;

    // Single full-adder cell: sum bit.
    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    // Single full-adder cell: carry (majority of the three inputs).
    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    // A start is only honoured outside RUN; there is no queueing or abort.
    assign accept   = start && (state != S_RUN);
    assign last_bit = (state == S_RUN) && (cnt == LAST_BIT);

    // Current bit of the ripple, taken from the LSBs of the shift registers.
    assign s_bit     = fa_sum(a_sh[0], b_sh[0], carry);
    assign c_bit     = fa_carry(a_sh[0], b_sh[0], carry);
    assign sum_final = {s_bit, sum_sh[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE/DONE accept a start, RUN counts out WIDTH bits.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == LAST_BIT) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // Serial datapath: load on accept, shift one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_sh <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sh <= '0;
        end else if (state == S_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= c_bit;
            cnt    <= cnt + CNT_ONE;
            sum_sh <= sum_final;
        end
    end

    // Visible result register, loaded only as the final bit completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else if (last_bit) begin
            sum_r  <= sum_final;
            cout_r <= c_bit;
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    // Operand sign bits are consumed by the shifters, so keep copies for ovf.
    logic a_sgn;
    logic b_sgn;
    logic ovf_r;

    // Capture operand signs on accept; register overflow alongside sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sgn <= 1'b0;
            b_sgn <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            if (accept) begin
                a_sgn <= a[WIDTH-1];
                b_sgn <= b[WIDTH-1];
            end
            if (last_bit) begin
                // Final s_bit is the sum MSB.
                ovf_r <= (a_sgn == b_sgn) && (s_bit != a_sgn);
            end
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial ripple adder: adds two WIDTH-bit operands plus carry-in one bit per clock, LSB first, using a single full-adder cell and a carry flop. It sits beside the combinational half/full adder cells in the arithmetic library and is the area-minimal, multi-cycle option for datapaths where WIDTH-bit combinational carry chains are too large. A start/busy/done handshake frames each operation. The result is held stable until the next accepted start.

## Interface

Parameters:
- WIDTH, default 8: operand and sum width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse: sum/cout valid from this cycle.
- sum  output  WIDTH  result, held until next accepted start.
- cout  output  1  carry-out of the MSB, held with sum.
- ovf  output  1  signed (two's complement) overflow; see Configuration.

## Operation

- States: IDLE, RUN, DONE. Encoding is implementation choice.
- IDLE: busy=0, done=0. start=1 -> capture a, b into shift registers, cin into carry flop, clear bit counter, clear sum shift register, go RUN.
- RUN: busy=1. Each cycle: s = a0 ^ b0 ^ c; c' = majority(a0, b0, c); shift a, b right by one; shift s into sum MSB (sum shifts right). Counter increments. After the WIDTH-th bit -> DONE. start ignored in RUN (no queueing, no abort).
- DONE: done=1, busy=0, sum holds full result, cout = final carry. start=1 -> accept new operands (same as IDLE), go RUN; otherwise go IDLE.
- sum/cout/ovf never show partial values outside RUN: visible sum register is updated only on entry to DONE (internal shift register separate).
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1); exact, no saturation.
- Counter width: $clog2(WIDTH)+1 bits; terminal count WIDTH-1.

## Timing

- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state=IDLE, counter=0, carry=0.
- start high in cycle 0 (accepted on edge ending cycle 0): busy=1 in cycles 1..WIDTH; done=1 in cycle WIDTH+1; sum/cout/ovf valid from cycle WIDTH+1.
- Latency start->done: WIDTH+1 cycles. Throughput with back-to-back starts (start held high in DONE): one result per WIDTH+1 cycles.
- Operands may change freely after the accepting edge.
- rst during RUN or DONE: next cycle is IDLE with all outputs at reset values; in-flight operation discarded, no done pulse.
- rst and start same edge: rst wins; start ignored.

## Configuration

- SERIAL_ADDER_OVERFLOW_EN defined: ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]), computed from captured operand sign bits (extra 2 flops) and registered with sum on entry to DONE; held with sum; reset 0.
- Not defined: ovf tied constant 0; no sign-capture flops synthesised. Port list identical in both builds.

## Test plan

- Reset: assert rst 2 cycles with start=1 -> busy=0, done=0, sum=0, cout=0, ovf=0 throughout and after release.
- WIDTH=8, a=8'h35, b=8'h4A, cin=0, start 1 cycle -> busy high cycles 1..8, done pulse cycle 9, sum=8'h7F, cout=0; sum held 8'h7F 10 cycles later.
- WIDTH=8, a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1; ovf=0 (with macro).
- WIDTH=8, a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0; ovf=1 with SERIAL_ADDER_OVERFLOW_EN, 0 without.
- Back-to-back: start held high, operands (8'h10,8'h20,0) then (8'hF0,8'h20,0) changed on DONE cycle -> done in cycles 9 and 18, sums 8'h30 then 8'h10 cout=1; start pulses during RUN ignored.
- rst asserted in cycle 4 of RUN -> cycle 5 IDLE, busy=0, no done pulse, sum=0; subsequent exhaustive sweep WIDTH=4 over all a,b,cin matches a+b+cin.
